// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file for the core datapath.
// Two write ports (ALU writeback and load return), two combinational read
// ports with optional same-cycle bypass, a per-register pending-load
// scoreboard, and a sequencer that zeroes the array after reset.
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic [AW-1:0]    a1,
  input  logic [AW-1:0]    a2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2,
  input  logic             we3,
  input  logic [AW-1:0]    a3,
  input  logic [WIDTH-1:0] wd3,
  input  logic             we4,
  input  logic [AW-1:0]    a4,
  input  logic [WIDTH-1:0] wd4,
  input  logic             pend_set,
  input  logic [AW-1:0]    pend_a
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_clr_ptr;
  logic             r_ready;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_pend;

  logic             w_run;
  logic             w_we3;
  logic             w_we4;
  logic             w_we4_clr;
  logic             w_pset;
  logic [AW-1:0]    w_ra   [2];
  logic [WIDTH-1:0] w_rd   [2];
  logic             w_busy [2];

  // Next-state logic: leave CLEAR once the last entry has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_ptr == AW'(DEPTH - 1)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // State register, clear pointer and registered ready flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_RUN);
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + AW'(1);
      end
    end
  end

  // Write qualification: only in RUN, and never to register 0 when it is hardwired
  always_comb begin
    w_run     = (r_state == ST_RUN);
    w_we3     = w_run && we3 && !((ZERO_REG != 0) && (a3 == '0));
    w_we4     = w_run && we4 && !((ZERO_REG != 0) && (a4 == '0));
    w_we4_clr = w_run && we4;
    w_pset    = w_run && pend_set && !((ZERO_REG != 0) && (pend_a == '0));
  end

  // Array update: zero sweep during CLEAR, ALU and load writes during RUN (ALU last so it wins a collision)
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else begin
      if (w_we4) begin
        r_mem[a4] <= wd4;
      end
      if (w_we3) begin
        r_mem[a3] <= wd3;
      end
    end
  end

  // Scoreboard: load return clears, pend_set applied last so it wins on the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      if (w_we4_clr) begin
        r_pend[a4] <= 1'b0;
      end
      if (w_pset) begin
        r_pend[pend_a] <= 1'b1;
      end
    end
  end

  // Read ports: zero during CLEAR, zero register override, then optional bypass
  always_comb begin
    w_ra[0] = a1;
    w_ra[1] = a2;
    for (int p = 0; p < 2; p++) begin
      w_rd[p]   = '0;
      w_busy[p] = 1'b0;
      if (!w_run) begin
        w_rd[p]   = '0;
        w_busy[p] = 1'b0;
      end else if ((ZERO_REG != 0) && (w_ra[p] == '0)) begin
        w_rd[p]   = '0;
        w_busy[p] = 1'b0;
      end else if (BYPASS != 0) begin
        if (w_we3 && (a3 == w_ra[p])) begin
          w_rd[p] = wd3;
        end else if (w_we4 && (a4 == w_ra[p])) begin
          w_rd[p] = wd4;
        end else begin
          w_rd[p] = r_mem[w_ra[p]];
        end
        w_busy[p] = r_pend[w_ra[p]] && !(w_we4_clr && (a4 == w_ra[p]));
      end else begin
        w_rd[p]   = r_mem[w_ra[p]];
        w_busy[p] = r_pend[w_ra[p]];
      end
    end
  end

  assign ready = r_ready;
  assign rd1   = w_rd[0];
  assign rd2   = w_rd[1];
  assign busy1 = w_busy[0];
  assign busy2 = w_busy[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives one bypassing and one non-bypassing regfile_sb with
// the same stimulus and checks both against a behavioural register-file model.
module tb_regfile_sb;

  localparam int W = 16;
  localparam int D = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         we3, we4, pend_set;
  logic [A-1:0] a1, a2, a3, a4, pend_a;
  logic [W-1:0] wd3, wd4;

  logic         ready_b, busy1_b, busy2_b, ready_n, busy1_n, busy2_n;
  logic [W-1:0] rd1_b, rd2_b, rd1_n, rd2_n;

  // sampled outputs of the cycle just stepped
  logic         s_ready_b, s_busy1_b, s_busy2_b, s_ready_n, s_busy1_n, s_busy2_n;
  logic [W-1:0] s_rd1_b, s_rd2_b, s_rd1_n, s_rd2_n;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [W-1:0] m_mem  [D];
  bit           m_pend [D];
  int           m_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .ready(ready_b),
    .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b), .busy1(busy1_b), .busy2(busy2_b),
    .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4), .wd4(wd4),
    .pend_set(pend_set), .pend_a(pend_a)
  );

  regfile_sb #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .ready(ready_n),
    .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n), .busy1(busy1_n), .busy2(busy2_n),
    .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4), .wd4(wd4),
    .pend_set(pend_set), .pend_a(pend_a)
  );

  function automatic logic [W-1:0] exp_rd(input int a, input bit byp);
    if (m_cnt < D) return '0;
    if (a == 0) return '0;
    if (byp && we3 && (int'(a3) == a)) return wd3;
    if (byp && we4 && (int'(a4) == a)) return wd4;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a, input bit byp);
    if (m_cnt < D) return 1'b0;
    if (a == 0) return 1'b0;
    if (byp && we4 && (int'(a4) == a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // apply the effect of one clock edge to the model, using the inputs it sampled
  task automatic model_tick();
    if (rst) begin
      m_cnt = 0;
      for (int i = 0; i < D; i++) m_pend[i] = 1'b0;
    end else if (m_cnt < D) begin
      m_cnt++;
      if (m_cnt == D) begin
        for (int i = 0; i < D; i++) m_mem[i] = '0;
      end
    end else begin
      if (we4 && a4 != 0) m_mem[a4] = wd4;
      if (we3 && a3 != 0) m_mem[a3] = wd3;
      if (we4) m_pend[a4] = 1'b0;
      if (pend_set && pend_a != 0) m_pend[pend_a] = 1'b1;
    end
  endtask

  // called 1 time unit after a posedge with inputs already driven
  task automatic step();
    #3;
    s_ready_b = ready_b; s_rd1_b = rd1_b; s_rd2_b = rd2_b; s_busy1_b = busy1_b; s_busy2_b = busy2_b;
    s_ready_n = ready_n; s_rd1_n = rd1_n; s_rd2_n = rd2_n; s_busy1_n = busy1_n; s_busy2_n = busy2_n;
    chk("ready_b", 32'(s_ready_b), 32'(m_cnt >= D));
    chk("ready_n", 32'(s_ready_n), 32'(m_cnt >= D));
    chk("rd1_b",   32'(s_rd1_b),   32'(exp_rd(int'(a1), 1'b1)));
    chk("rd2_b",   32'(s_rd2_b),   32'(exp_rd(int'(a2), 1'b1)));
    chk("rd1_n",   32'(s_rd1_n),   32'(exp_rd(int'(a1), 1'b0)));
    chk("rd2_n",   32'(s_rd2_n),   32'(exp_rd(int'(a2), 1'b0)));
    chk("busy1_b", 32'(s_busy1_b), 32'(exp_busy(int'(a1), 1'b1)));
    chk("busy2_b", 32'(s_busy2_b), 32'(exp_busy(int'(a2), 1'b1)));
    chk("busy1_n", 32'(s_busy1_n), 32'(exp_busy(int'(a1), 1'b0)));
    chk("busy2_n", 32'(s_busy2_n), 32'(exp_busy(int'(a2), 1'b0)));
    @(posedge clk);
    #1;
    model_tick();
  endtask

  task automatic idle();
    rst = 1'b0; we3 = 1'b0; we4 = 1'b0; pend_set = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we3 = 1'b0; we4 = 1'b0; pend_set = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; a4 = '0; pend_a = '0; wd3 = '0; wd4 = '0;
    m_cnt = 0;
    for (int i = 0; i < D; i++) begin m_mem[i] = '0; m_pend[i] = 1'b0; end
    @(posedge clk);
    #1;
    model_tick();

    // reset state
    step();
    chk("reset_ready", 32'(s_ready_b), 32'h0);

    // clear sequence with stray traffic that must be ignored
    rst = 1'b0; we3 = 1'b1; a3 = 5'd5; wd3 = 16'hBEEF;
    we4 = 1'b1; a4 = 5'd5; wd4 = 16'h1111; pend_set = 1'b1; pend_a = 5'd6;
    a1 = 5'd5; a2 = 5'd6;
    for (int k = 0; k < D; k++) begin
      step();
      chk($sformatf("clr_ready_low_%0d", k), 32'(s_ready_n), 32'h0);
    end
    idle();
    step();
    chk("clr_ready_high", 32'(s_ready_b), 32'h1);
    chk("clr_reg5_zero", 32'(s_rd1_n), 32'h0);
    chk("clr_reg6_not_busy", 32'(s_busy2_n), 32'h0);
    for (int i = 0; i < D; i++) begin
      a1 = 5'(i); a2 = 5'(D - 1 - i);
      step();
      chk($sformatf("clr_zero_%0d", i), 32'(s_rd1_n), 32'h0);
    end

    // basic write/read latency
    we3 = 1'b1; a3 = 5'd7; wd3 = 16'h1234; a1 = 5'd7;
    step();
    chk("wr_same_cycle_nobyp", 32'(s_rd1_n), 32'h0);
    chk("wr_same_cycle_byp", 32'(s_rd1_b), 32'h1234);
    idle();
    step();
    chk("wr_next_cycle_nobyp", 32'(s_rd1_n), 32'h1234);

    // ALU/load collision priority
    we3 = 1'b1; a3 = 5'd9; wd3 = 16'hAAAA; we4 = 1'b1; a4 = 5'd9; wd4 = 16'h5555; a1 = 5'd9;
    step();
    chk("prio_byp", 32'(s_rd1_b), 32'hAAAA);
    idle();
    step();
    chk("prio_after_nobyp", 32'(s_rd1_n), 32'hAAAA);
    chk("prio_after_byp", 32'(s_rd1_b), 32'hAAAA);

    // scoreboard set, hold, clear
    pend_set = 1'b1; pend_a = 5'd3; a1 = 5'd3;
    step();
    idle();
    step();
    chk("pend_hold1_b", 32'(s_busy1_b), 32'h1);
    chk("pend_hold1_n", 32'(s_busy1_n), 32'h1);
    step();
    chk("pend_hold2_b", 32'(s_busy1_b), 32'h1);
    we4 = 1'b1; a4 = 5'd3; wd4 = 16'h00FF;
    step();
    chk("pend_clr_busy_byp", 32'(s_busy1_b), 32'h0);
    chk("pend_clr_rd_byp", 32'(s_rd1_b), 32'h00FF);
    idle();
    step();
    chk("pend_clr_after_n", 32'(s_busy1_n), 32'h0);
    // set and load return to the same register in one cycle: set wins
    pend_set = 1'b1; pend_a = 5'd3; we4 = 1'b1; a4 = 5'd3; wd4 = 16'h0F0F;
    step();
    idle();
    step();
    chk("pend_set_wins_b", 32'(s_busy1_b), 32'h1);
    chk("pend_set_wins_n", 32'(s_busy1_n), 32'h1);
    we4 = 1'b1; a4 = 5'd3; wd4 = 16'h0001;
    step();
    idle();

    // zero register
    we3 = 1'b1; a3 = 5'd0; wd3 = 16'hFFFF; we4 = 1'b1; a4 = 5'd0; wd4 = 16'hFFFF;
    pend_set = 1'b1; pend_a = 5'd0; a1 = 5'd0;
    step();
    chk("zero_rd_during", 32'(s_rd1_b), 32'h0);
    chk("zero_busy_during", 32'(s_busy1_b), 32'h0);
    idle();
    step();
    chk("zero_rd_after", 32'(s_rd1_n), 32'h0);
    chk("zero_busy_after", 32'(s_busy1_n), 32'h0);

    // randomized traffic, addresses often confined to a few registers to force collisions
    for (int n = 0; n < 400; n++) begin
      int hi;
      hi = ($urandom_range(0, 1) == 0) ? 3 : (D - 1);
      we3 = 1'($urandom); we4 = 1'($urandom); pend_set = 1'($urandom);
      a1 = 5'($urandom_range(0, hi)); a2 = 5'($urandom_range(0, hi));
      a3 = 5'($urandom_range(0, hi)); a4 = 5'($urandom_range(0, hi));
      pend_a = 5'($urandom_range(0, hi));
      wd3 = 16'($urandom); wd4 = 16'($urandom);
      step();
    end

    // reset in the middle of RUN
    idle();
    we3 = 1'b1; a3 = 5'd2; wd3 = 16'h7777; a1 = 5'd2;
    step();
    idle();
    for (int k = 0; k < 10; k++) step();
    chk("midrst_before", 32'(s_rd1_n), 32'h7777);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("midrst_ready_drop", 32'(s_ready_b), 32'h0);
    for (int k = 1; k < D; k++) step();
    step();
    chk("midrst_ready_back", 32'(s_ready_b), 32'h1);
    chk("midrst_reg2_zero_n", 32'(s_rd1_n), 32'h0);
    chk("midrst_reg2_zero_b", 32'(s_rd1_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file for the core datapath, replacing the fixed 32x16 single-write file. It adds a second write port for load returns, optional write-to-read bypass, a per-register pending-load scoreboard, and a post-reset clear sequencer. It sits between decode (read and issue side) and writeback (ALU and load return ports).

## Interface

- WIDTH, 16, data width in bits
- DEPTH, 32, number of registers, power of two, at least 4; AW = $clog2(DEPTH)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and pend sets
- BYPASS, 1, when 1, same-cycle writes forward to read ports

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high once the clear sequence has finished
- a1, a2  in  AW  read addresses
- rd1, rd2  out  WIDTH  read data (combinational)
- busy1, busy2  out  1  scoreboard pending bit for a1/a2 (combinational)
- we3  in  1  ALU writeback enable
- a3  in  AW  ALU writeback address
- wd3  in  WIDTH  ALU writeback data
- we4  in  1  load-return write enable; clears the pending bit of a4
- a4  in  AW  load-return address
- wd4  in  WIDTH  load-return data
- pend_set  in  1  mark a register as awaiting a load
- pend_a  in  AW  register to mark

## Operation

- States: CLEAR and RUN. rst=1 forces CLEAR, clr_ptr=0, ready=0, all pend bits 0.
- CLEAR:
  - Each cycle with rst=0, write 0 to entry clr_ptr, then clr_ptr++.
  - After the cycle that writes clr_ptr=DEPTH-1, move to RUN and set ready=1.
  - we3, we4 and pend_set are ignored.
  - rd1, rd2, busy1 and busy2 read as 0.
- RUN writes:
  - we3 writes wd3 to a3. we4 writes wd4 to a4.
  - Both ports enabled with a3==a4: wd3 wins. The pending bit of a4 is still cleared.
- Scoreboard:
  - pend_set sets pend[pend_a]. we4 clears pend[a4].
  - pend_set with pend_a==a4 and we4 in the same cycle: the set wins, and the bit ends at 1.
  - we3 does not affect pend.
- ZERO_REG=1: writes and pend_set to address 0 are dropped. rd and busy for address 0 are always 0.
- Reads with BYPASS=1:
  - rdN = wd3 if we3 and a3==aN.
  - Otherwise rdN = wd4 if we4 and a4==aN.
  - Otherwise rdN = array[aN].
  - busyN = pend[aN] AND NOT (we4 AND a4==aN).
- Reads with BYPASS=0: rdN = array[aN] and busyN = pend[aN], both pre-edge values.
- The zero-register rule overrides bypass.

## Timing

- Reset values: ready=0, all pend bits 0, clr_ptr=0. rd1, rd2, busy1 and busy2 read 0 during CLEAR.
- ready rises exactly DEPTH cycles after the first cycle with rst=0. With DEPTH=32, rst is low in cycle 0 and ready is 1 from cycle 32.
- rst asserted mid-CLEAR or mid-RUN: the next edge restarts CLEAR from clr_ptr=0 and drops ready. Array contents are not guaranteed until the clear completes.
- Write latency:
  - One edge: the array updates at the posedge where the enable is sampled.
  - With BYPASS=1, the new data is visible on rd in the same cycle.
  - With BYPASS=0, the new data is visible from the next cycle.
- Pend latency: a pend bit set at edge N reads busy=1 from cycle N+1. The bit stays set until the matching we4.
- No handshakes. Callers hold off write and issue traffic until ready=1; inputs driven during CLEAR have no effect.

## Test plan

- Reset/clear:
  - Pulse rst, then hold rst=0.
  - Required: ready=0 for cycles 0..31 and 1 at cycle 32.
  - Required: every register reads 0 after the clear.
  - Required: we3 to reg 5 with 0xBEEF issued during CLEAR leaves reg 5 at 0.
- Basic write/read (BYPASS=0):
  - we3, a3=7, wd3=0x1234.
  - Required: rd1 with a1=7 shows 0x1234 on the following cycle, not in the write cycle.
- Bypass and priority (BYPASS=1):
  - Same cycle: we3 a3=9 wd3=0xAAAA, we4 a4=9 wd4=0x5555, a1=9.
  - Required: rd1=0xAAAA that cycle, and reg 9 holds 0xAAAA afterwards.
- Scoreboard:
  - pend_set reg 3, then hold 2 cycles.
  - Required: busy1 (a1=3) is 1 throughout.
  - Then we4 a4=3 wd4=0x00FF. Required: busy1=0 and rd1=0x00FF in that cycle (BYPASS=1).
  - Repeat with pend_set and we4 to reg 3 in the same cycle. Required: busy stays 1.
- Zero register:
  - we3 to reg 0 with 0xFFFF, plus pend_set reg 0.
  - Required: rd1=0 and busy1=0 both during and after that cycle.
- Mid-operation reset:
  - Write 0x7777 to reg 2, run RUN for 10 cycles, assert rst for 1 cycle.
  - Required: ready=0 next cycle, ready=1 again 32 cycles after rst drops, and reg 2 reads 0.
